// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester (cpu/dbg) data-memory arbiter with lock bursts.
// Optional macro DM_ARB_RR_EN selects round-robin tie-breaking; default is fixed cpu priority.
module dm_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic        dbg_req,
  input  logic        cpu_lock,
  input  logic        dbg_lock,
  input  logic        cpu_we,
  input  logic        dbg_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  cpu_dmtype,
  input  logic [2:0]  dbg_dmtype,
  output logic        cpu_gnt,
  output logic        dbg_gnt,
  output logic        cpu_rvalid,
  output logic        dbg_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dbg_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_dmtype,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DBG} state_t;

  localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

  state_t     state;
  state_t     state_nx;
  logic [3:0] lock_cnt;
  logic       arb_rdy;
  logic       cpu_hold;
  logic       dbg_hold;
  logic       cpu_elig;
  logic       dbg_elig;
`ifdef DM_ARB_RR_EN
  logic       rr_dbg_pri;
`endif

  // A locked owner under its burst limit keeps the memory regardless of tie policy.
  always_comb begin
    cpu_hold = (state == GNT_CPU) && cpu_req && cpu_lock && (lock_cnt < LOCK_MAX);
    dbg_hold = (state == GNT_DBG) && dbg_req && dbg_lock && (lock_cnt < LOCK_MAX);
    cpu_elig = cpu_req && ((state != GNT_CPU) || cpu_hold);
    dbg_elig = dbg_req && ((state != GNT_DBG) || dbg_hold);
    state_nx = IDLE;
    if (arb_rdy) begin
      if (cpu_hold) begin
        state_nx = GNT_CPU;
      end else if (dbg_hold) begin
        state_nx = GNT_DBG;
      end else if (cpu_elig && dbg_elig) begin
`ifdef DM_ARB_RR_EN
        state_nx = rr_dbg_pri ? GNT_DBG : GNT_CPU;
`else
        state_nx = GNT_CPU;
`endif
      end else if (cpu_elig) begin
        state_nx = GNT_CPU;
      end else if (dbg_elig) begin
        state_nx = GNT_DBG;
      end
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_din    = 32'h0;
    mem_dmtype = 3'h0;
    if (cpu_gnt) begin
      mem_we     = cpu_we & cpu_gnt;
      mem_addr   = cpu_addr;
      mem_din    = cpu_wdata;
      mem_dmtype = cpu_dmtype;
    end else if (dbg_gnt) begin
      mem_we     = dbg_we & dbg_gnt;
      mem_addr   = dbg_addr;
      mem_din    = dbg_wdata;
      mem_dmtype = dbg_dmtype;
    end
  end

  // arb_rdy delays the first grant by one edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      arb_rdy    <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      lock_cnt   <= 4'd0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= 32'h0;
      dbg_rdata  <= 32'h0;
`ifdef DM_ARB_RR_EN
      rr_dbg_pri <= 1'b0;
`endif
    end else begin
      arb_rdy <= 1'b1;
      state   <= state_nx;
      cpu_gnt <= (state_nx == GNT_CPU);
      dbg_gnt <= (state_nx == GNT_DBG);
      if (state_nx == IDLE) begin
        lock_cnt <= 4'd0;
      end else if (state_nx == state) begin
        lock_cnt <= lock_cnt + 4'd1;
      end else begin
        lock_cnt <= 4'd1;
      end
      cpu_rvalid <= (state == GNT_CPU) && !cpu_we;
      dbg_rvalid <= (state == GNT_DBG) && !dbg_we;
      if ((state == GNT_CPU) && !cpu_we) begin
        cpu_rdata <= mem_dout;
      end
      if ((state == GNT_DBG) && !dbg_we) begin
        dbg_rdata <= mem_dout;
      end
`ifdef DM_ARB_RR_EN
      if (state_nx == GNT_CPU) begin
        rr_dbg_pri <= 1'b1;
      end else if (state_nx == GNT_DBG) begin
        rr_dbg_pri <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter with a small word memory.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req, dbg_req, cpu_lock, dbg_lock, cpu_we, dbg_we;
  logic [31:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata;
  logic [2:0]  cpu_dmtype, dbg_dmtype;
  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_dmtype;
  logic [31:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .dbg_req(dbg_req), .cpu_lock(cpu_lock), .dbg_lock(dbg_lock),
    .cpu_we(cpu_we), .dbg_we(dbg_we), .cpu_addr(cpu_addr), .dbg_addr(dbg_addr),
    .cpu_wdata(cpu_wdata), .dbg_wdata(dbg_wdata), .cpu_dmtype(cpu_dmtype), .dbg_dmtype(dbg_dmtype),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dmtype(mem_dmtype),
    .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] <= mem_din;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [1:0] exp);
    chk(tag, {30'h0, cpu_gnt, dbg_gnt}, {30'h0, exp});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    rstn = 1'b0;
    cpu_req = 0; dbg_req = 0; cpu_lock = 0; dbg_lock = 0; cpu_we = 0; dbg_we = 0;
    cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0; cpu_dmtype = 0; dbg_dmtype = 0;
    tick();
    tick();
    chk_gnt("reset_gnt", 2'b00);
    chk("reset_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'h0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    chk("reset_dbg_rdata", dbg_rdata, 32'h0);
    chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);

    // CPU read of 0x10; first grant only at the second edge after release
    rstn = 1'b1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_dmtype = 3'd2;
    tick();
    chk_gnt("first_edge_no_gnt", 2'b00);
    tick();
    chk_gnt("rd_gnt", 2'b10);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_dmtype", {29'h0, mem_dmtype}, 32'd2);
    chk("rd_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rd_rvalid_early", {31'h0, cpu_rvalid}, 32'h0);
    cpu_req = 0;
    tick();
    chk_gnt("rd_after_gnt", 2'b00);
    chk("rd_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("idle_mem_addr", mem_addr, 32'h0);
    tick();
    chk("rd_rvalid_pulse", {31'h0, cpu_rvalid}, 32'h0);
    chk("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // DBG write of 0x12345678 to 0x20, then CPU reads it back
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h12345678; dbg_dmtype = 3'd2;
    tick();
    chk_gnt("wr_gnt", 2'b01);
    chk("wr_mem_we", {31'h0, mem_we}, 32'h1);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_din", mem_din, 32'h12345678);
    dbg_req = 0;
    tick();
    chk("wr_mem_we_off", {31'h0, mem_we}, 32'h0);
    chk("wr_no_rvalid", {31'h0, dbg_rvalid}, 32'h0);
    dbg_we = 0;
    cpu_req = 1; cpu_addr = 32'h20;
    tick();
    chk_gnt("rb_gnt", 2'b10);
    cpu_req = 0;
    tick();
    chk("rb_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    chk("rb_rdata", cpu_rdata, 32'h12345678);

    // Tie: both requests held across reset exit
    rstn = 1'b0;
    cpu_req = 1; dbg_req = 1; cpu_addr = 32'h10; dbg_addr = 32'h20;
    tick();
    rstn = 1'b1;
    tick();
    chk_gnt("tie_first_edge", 2'b00);
    tick();
    chk_gnt("tie_1_cpu", 2'b10);
    tick();
    chk_gnt("tie_2_dbg", 2'b01);
    chk("tie_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    tick();
    chk_gnt("tie_3_cpu", 2'b10);
    chk("tie_dbg_rdata", dbg_rdata, 32'h12345678);
    tick();
    chk_gnt("tie_4_dbg", 2'b01);
    cpu_req = 0; dbg_req = 0;
    tick();
    tick();
    chk_gnt("tie_idle", 2'b00);

    // Lock burst: dbg holds for MAX_LOCK grants, cpu slips in, dbg resumes
    dbg_req = 1; dbg_lock = 1;
    tick();
    chk_gnt("lock_1", 2'b01);
    cpu_req = 1;
    tick();
    chk_gnt("lock_2", 2'b01);
    tick();
    chk_gnt("lock_3", 2'b01);
    tick();
    chk_gnt("lock_4", 2'b01);
    tick();
    chk_gnt("lock_cpu", 2'b10);
    tick();
    chk_gnt("lock_resume", 2'b01);
    cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    tick();
    tick();
    chk_gnt("lock_idle", 2'b00);

    // Reset during a CPU write gnt cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    tick();
    chk("rst_pre_mem_we", {31'h0, mem_we}, 32'h1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mem_we_async", {31'h0, mem_we}, 32'h0);
    chk_gnt("rst_gnt_async", 2'b00);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    chk("rst_no_rvalid", {30'h0, cpu_rvalid, dbg_rvalid}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_no_write", mem[12], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
